// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit; define MULDIV_ACC_EN to add MADD/MADDU/MSUB/MSUBU.
// Latency MUL_CYCLES (mul), 33 (div), 1 (div by zero); busy stalls issue, start ignored while busy.
module muldiv_unit #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  inst,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int DIV_CYCLES = 33;

    // Decoder instruction codes, mirrored from the INST_* definitions.
    localparam logic [7:0] INST_MTHI  = 8'h11;
    localparam logic [7:0] INST_MTLO  = 8'h13;
    localparam logic [7:0] INST_MULT  = 8'h18;
    localparam logic [7:0] INST_MULTU = 8'h19;
    localparam logic [7:0] INST_DIV   = 8'h1A;
    localparam logic [7:0] INST_DIVU  = 8'h1B;
`ifdef MULDIV_ACC_EN
    localparam logic [7:0] INST_MADD  = 8'h1C;
    localparam logic [7:0] INST_MADDU = 8'h1D;
    localparam logic [7:0] INST_MSUB  = 8'h1E;
    localparam logic [7:0] INST_MSUBU = 8'h1F;
    localparam logic [1:0] ACC_NONE   = 2'd0;
    localparam logic [1:0] ACC_ADD    = 2'd1;
    localparam logic [1:0] ACC_SUB    = 2'd2;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DZ} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] rem_q, rem_d;
    logic        sgn_q, sgn_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
`ifdef MULDIV_ACC_EN
    logic [1:0]  mode_q, mode_d;
    logic [63:0] base_q, base_d;
`endif

    logic [63:0] ext_a, ext_b, prod, mul_res;
    logic [32:0] shifted, trial;

    // Low 64 bits of a 64x64 product are correct for both signednesses once extended.
    assign ext_a   = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign ext_b   = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign prod    = ext_a * ext_b;
    assign shifted = {rem_q, a_q[31]};
    assign trial   = shifted - {1'b0, b_q};

`ifdef MULDIV_ACC_EN
    always_comb begin
        mul_res = prod;
        case (mode_q)
            ACC_ADD: mul_res = base_q + prod;
            ACC_SUB: mul_res = base_q - prod;
            default: mul_res = prod;
        endcase
    end
`else
    assign mul_res = prod;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_ACC_EN
        mode_d  = mode_q;
        base_d  = base_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (inst)
                        INST_MTHI: hi_d = op_a;
                        INST_MTLO: lo_d = op_a;
                        INST_MULT, INST_MULTU: begin
                            a_d     = op_a;
                            b_d     = op_b;
                            sgn_d   = (inst == INST_MULT);
                            cnt_d   = 6'd1;
                            state_d = S_MUL;
`ifdef MULDIV_ACC_EN
                            mode_d  = ACC_NONE;
`endif
                        end
`ifdef MULDIV_ACC_EN
                        INST_MADD, INST_MADDU, INST_MSUB, INST_MSUBU: begin
                            a_d     = op_a;
                            b_d     = op_b;
                            sgn_d   = (inst == INST_MADD) || (inst == INST_MSUB);
                            cnt_d   = 6'd1;
                            state_d = S_MUL;
                            mode_d  = ((inst == INST_MADD) || (inst == INST_MADDU)) ? ACC_ADD : ACC_SUB;
                            base_d  = {hi_q, lo_q};
                        end
`endif
                        INST_DIV, INST_DIVU: begin
                            if (op_b == 32'd0) begin
                                state_d = S_DZ;
                            end else begin
                                // Divide on magnitudes; signs are restored in the fix-up cycle.
                                a_d     = ((inst == INST_DIV) && op_a[31]) ? -op_a : op_a;
                                b_d     = ((inst == INST_DIV) && op_b[31]) ? -op_b : op_b;
                                negq_d  = (inst == INST_DIV) && (op_a[31] ^ op_b[31]);
                                negr_d  = (inst == INST_DIV) && op_a[31];
                                rem_d   = 32'd0;
                                cnt_d   = 6'd1;
                                state_d = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 6'(MUL_CYCLES)) begin
                    {hi_d, lo_d} = mul_res;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 6'(DIV_CYCLES)) begin
                    lo_d    = negq_q ? -a_q : a_q;
                    hi_d    = negr_q ? -rem_q : rem_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // a_q doubles as the dividend shifter and the quotient accumulator.
                    if (!trial[32]) begin
                        rem_d = trial[31:0];
                        a_d   = {a_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        a_d   = {a_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DZ: begin
                state_d = S_IDLE;
                done_d  = !flush;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 32'd0;
            sgn_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
`ifdef MULDIV_ACC_EN
            mode_q  <= 2'd0;
            base_q  <= 64'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_ACC_EN
            mode_q  <= mode_d;
            base_q  <= base_d;
`endif
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset, mul/div results and latency, div by zero, flush, stall, accumulate.
module tb_muldiv_unit;

    localparam logic [7:0] MTHI  = 8'h11;
    localparam logic [7:0] MTLO  = 8'h13;
    localparam logic [7:0] MULT  = 8'h18;
    localparam logic [7:0] MULTU = 8'h19;
    localparam logic [7:0] DIV   = 8'h1A;
    localparam logic [7:0] DIVU  = 8'h1B;
    localparam logic [7:0] MADD  = 8'h1C;
    localparam logic [7:0] MSUBU = 8'h1F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  inst;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .inst  (inst),
        .op_a  (op_a),
        .op_b  (op_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] i, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        inst  = i;
        op_a  = a;
        op_b  = b;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles after the accept edge until done shows, noting whether busy held meanwhile.
    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (done === 1'b1) cnt++;
        end
    endtask

    initial begin
        int  n;
        int  dcnt;
        bit  bok;

        rst_n = 1'b0; start = 1'b0; inst = 8'h00; op_a = '0; op_b = '0; flush = 1'b0;
        #1;
        chk("reset_hi",   64'(hi),   64'h0);
        chk("reset_lo",   64'(lo),   64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // MULT -2 * 3
        issue(MULT, 32'hFFFFFFFE, 32'd3);
        wait_done(n, bok);
        chk("mult_latency", 64'(n), 64'd3);
        chk("mult_busy",    64'(bok), 64'd1);
        chk("mult_busy_at_done", 64'(busy), 64'd0);
        chk("mult_hilo",    {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        tick();
        chk("mult_done_pulse", 64'(done), 64'd0);

        issue(MULTU, 32'hFFFFFFFE, 32'd3);
        wait_done(n, bok);
        chk("multu_latency", 64'(n), 64'd3);
        chk("multu_hilo",    {hi, lo}, 64'h00000002_FFFFFFFA);
        tick();

        issue(DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(n, bok);
        chk("div_latency", 64'(n), 64'd33);
        chk("div_busy",    64'(bok), 64'd1);
        chk("div_hilo",    {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        tick();

        issue(DIVU, 32'd7, 32'd2);
        wait_done(n, bok);
        chk("divu_latency", 64'(n), 64'd33);
        chk("divu_hilo",    {hi, lo}, 64'h00000001_00000003);
        tick();

        issue(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n, bok);
        chk("div_min_hilo", {hi, lo}, 64'h00000000_80000000);
        tick();

        issue(MTHI, 32'h11, 32'd0);
        chk("mthi_hi",   64'(hi),   64'h11);
        chk("mthi_busy", 64'(busy), 64'h0);
        issue(MTLO, 32'h22, 32'd0);
        chk("mtlo_lo",   64'(lo),   64'h22);
        chk("mtlo_done", 64'(done), 64'h0);

        issue(DIV, 32'd5, 32'd0);
        wait_done(n, bok);
        chk("dz_latency", 64'(n), 64'd1);
        chk("dz_hilo",    {hi, lo}, 64'h00000011_00000022);
        tick();

        flush = 1'b1;
        issue(MTHI, 32'hDEAD, 32'd0);
        flush = 1'b0;
        chk("flush_mthi_hi", 64'(hi), 64'h11);

        // Flush in the tenth busy cycle of a divide
        issue(DIV, 32'd100, 32'd7);
        repeat (9) tick();
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_after", 64'(busy), 64'd0);
        chk("flush_done",       64'(done), 64'd0);
        count_done(40, dcnt);
        chk("flush_no_done",    64'(dcnt), 64'd0);
        chk("flush_hilo",       {hi, lo}, 64'h00000011_00000022);

        // MULT presented while busy must be dropped
        issue(DIVU, 32'd9, 32'd2);
        tick();
        issue(MULT, 32'd5, 32'd5);
        wait_done(n, bok);
        chk("stall_latency", 64'(n + 2), 64'd33);
        chk("stall_hilo",    {hi, lo}, 64'h00000001_00000004);
        // New start in the done cycle
        issue(MULTU, 32'd4, 32'd5);
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done(n, bok);
        chk("b2b_latency", 64'(n), 64'd3);
        chk("b2b_hilo",    {hi, lo}, 64'h00000000_00000014);
        tick();

        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'd5, 32'd0);
`ifdef MULDIV_ACC_EN
        issue(MADD, 32'd2, 32'd3);
        wait_done(n, bok);
        chk("madd_latency", 64'(n), 64'd3);
        chk("madd_hilo",    {hi, lo}, 64'h00000000_0000000B);
        tick();
        issue(MSUBU, 32'd1, 32'd12);
        wait_done(n, bok);
        chk("msubu_hilo",   {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
        tick();
`else
        issue(MADD, 32'd2, 32'd3);
        chk("madd_off_busy", 64'(busy), 64'd0);
        count_done(4, dcnt);
        chk("madd_off_done", 64'(dcnt), 64'd0);
        issue(MSUBU, 32'd1, 32'd12);
        chk("msubu_off_busy", 64'(busy), 64'd0);
        count_done(4, dcnt);
        chk("msubu_off_done", 64'(dcnt), 64'd0);
        chk("acc_off_hilo",   {hi, lo}, 64'h00000000_00000005);
`endif

        // Asynchronous reset in the middle of a divide
        issue(DIV, 32'd100, 32'd7);
        repeat (5) tick();
        chk("arst_pre_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi",   64'(hi),   64'h0);
        chk("arst_lo",   64'(lo),   64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_done", 64'(done), 64'h0);
        tick();
        rst_n = 1'b1;
        count_done(40, dcnt);
        chk("arst_no_done", 64'(dcnt), 64'd0);
        chk("arst_idle",    64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage HI/LO unit, directly downstream of the R-type decoder.
- Consumes the decoded 8-bit inst code plus the rs/rt operand values, and owns the architectural HI and LO registers.
- Multiply and divide run over multiple cycles; busy drives the pipeline stall.
- Operations: MULT/MULTU, DIV/DIVU, MTHI/MTLO, and optionally MADD/MADDU/MSUB/MSUBU.

Parameters:
- MUL_CYCLES, 3, cycles from accept to HI/LO write for multiply ops (legal 1..8).
- DIV_CYCLES, 33, cycles from accept to HI/LO write for DIV/DIVU (32 iterations plus 1 sign fix-up; fixed, not to be overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  inst/op_a/op_b are valid this cycle.
- inst  in  8  decoded instruction code, compared against the `INST_* codes in defs.v.
- op_a  in  32  rs value.
- op_b  in  32  rt value.
- flush  in  1  abort any in-flight operation (exception or branch squash).
- busy  out  1  multi-cycle operation in flight; ID stalls while it is high.
- done  out  1  one-cycle pulse; HI/LO updated on the preceding edge by a multi-cycle op.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, state IDLE, counter=0. Reset mid-operation discards the operation; no done is produced.
- States:
  - IDLE: start=1 & flush=0.
    - MTHI: hi<=op_a at this edge; stay IDLE; no busy, no done.
    - MTLO: lo<=op_a at this edge; stay IDLE; no busy, no done.
    - MULT/MULTU (and accumulate ops when enabled): latch operands and op; go MUL.
    - DIV/DIVU with op_b!=0: latch operands; go DIV.
    - DIV/DIVU with op_b==0: go DZ.
    - Any other inst: ignored.
  - MUL: counter runs 1..MUL_CYCLES.
    - At the edge ending cycle MUL_CYCLES after accept, write {hi,lo}.
    - MULT: signed 64-bit product.
    - MULTU: unsigned 64-bit product.
    - MADD/MADDU: {hi,lo}+product.
    - MSUB/MSUBU: {hi,lo}-product.
    - Accumulate arithmetic is 64-bit modulo 2^64, signedness per op; the {hi,lo} value used is the one at accept time.
    - Then go IDLE; busy=0, done=1 for one cycle.
  - DIV: restoring divide on magnitudes, one quotient bit per cycle over 32 cycles; then 1 fix-up cycle.
    - Quotient is negated if operand signs differ (DIV only).
    - Remainder takes the sign of the dividend (DIV only).
    - lo<=quotient, hi<=remainder at accept+DIV_CYCLES; then IDLE, done pulse.
    - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DZ: one cycle; hi/lo unchanged; next edge IDLE with a done pulse.
- Handshake and timing:
  - busy=1 from the edge after accept until the edge that writes HI/LO; busy=0 in the cycle done=1.
  - start while busy=1 is ignored; ID guarantees it holds the instruction.
  - A new start is accepted in the same cycle that done=1.
- flush:
  - In MUL/DIV/DZ: return to IDLE at the next edge; hi/lo unchanged; no done; busy=0 after that edge.
  - flush and start in the same cycle: flush wins, start is ignored, including MTHI/MTLO.
- hi/lo are read directly by MFHI/MFLO. No forwarding is needed, since writes are only visible after the edge.

Optional Feature:
- Macro: MULDIV_ACC_EN.
- Defined: MADD, MADDU, MSUB and MSUBU are accepted and execute in MUL as above.
- Undefined: those four inst codes are ignored like any unknown inst (no busy, no done, hi/lo unchanged). The accumulate adder/subtractor is not synthesized.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-DIV -> hi=0, lo=0, busy=0, done=0 immediately; no done after release.
- MULT op_a=0xFFFFFFFE, op_b=3 -> exactly 3 cycles later hi=0xFFFFFFFF, lo=0xFFFFFFFA with done pulse. Repeat as MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> busy for 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat as DIVU 7/2 -> lo=3, hi=1. Repeat as DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO; DIV op_b=0 -> done 1 cycle after accept; hi=0x11, lo=0x22.
- Flush and stall:
  - Flush on cycle 10 of a DIV -> busy=0 next cycle, no done, hi/lo unchanged.
  - A MULT presented with start while busy -> not executed.
  - flush+MTHI in the same cycle -> hi unchanged.
- Accumulate: hi=0, lo=5; MADD op_a=2, op_b=3 -> lo=11, hi=0. MSUBU with op_a=1, op_b=12 from that state -> {hi,lo}=0xFFFFFFFF_FFFFFFFF. With MULDIV_ACC_EN undefined -> both ignored, busy stays 0.
